wave_sum_tree: RTL and testbench
================================

WAVE_SUM_TREE -- requirements
Module: wave_sum_tree

Interface
REQ-001 Parameter NUM_CH, default 64: channel count; power of two, 2..64.
REQ-002 Parameter SAMPLE_W, default 16: signed sample width per channel and at the output.
REQ-003 Derived constant LOG2_CH = log2(NUM_CH): tree depth; internal accumulator width ACC_W = SAMPLE_W + LOG2_CH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low = reset asserted.
REQ-006 in_valid  input  1  a sample set is presented on samples this cycle.
REQ-007 samples  input  NUM_CH*SAMPLE_W  signed channel samples; channel k occupies bits [k*SAMPLE_W +: SAMPLE_W].
REQ-008 ch_en  input  NUM_CH  per-channel enable, sampled with in_valid; a disabled channel contributes 0.
REQ-009 avg_mode  input  1  0 = saturating sum, 1 = mean (sum arithmetic-shifted right by LOG2_CH); sampled with in_valid.
REQ-010 sat_clr  input  1  synchronous clear of sat_flag.
REQ-011 out_valid  output  1  result is valid this cycle.
REQ-012 result  output  SAMPLE_W  signed mixed sample.
REQ-013 sat_flag  output  1  sticky: at least one result was clipped since the last clear.

Function
- REQ-014 The block SHALL sum the enabled channel samples through a binary adder tree with one register stage per level (LOG2_CH stages) plus one output stage.
- REQ-015 Latency SHALL be exactly LOG2_CH+1 cycles from in_valid high to the matching out_valid high; throughput SHALL be one sample set per cycle, with no stall or backpressure.
- REQ-016 Each tree level SHALL widen by one bit and sign-extend its operands, so no intermediate overflow occurs; the final sum is ACC_W bits, exact.
- REQ-017 A valid bit SHALL travel alongside each pipeline stage; stages holding invalid data SHALL still shift, and out_valid SHALL be low for them.
- REQ-018 avg_mode and ch_en SHALL be captured at the first stage and carried with the data, so mode changes never corrupt samples already in flight.
- REQ-019 avg_mode=1: result SHALL equal the ACC_W sum arithmetic-shifted right by LOG2_CH (floor), which always fits in SAMPLE_W; sat_flag is unaffected.
- REQ-020 avg_mode=0: result SHALL equal the sum clipped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- REQ-021 When clipping occurs on a valid output, sat_flag SHALL be set in the same cycle out_valid is high.
- REQ-022 sat_flag SHALL hold until sat_clr; if sat_clr and a new clip coincide, set SHALL win.
- REQ-023 result SHALL hold its last value while out_valid is low.
- REQ-024 With all ch_en low, result SHALL be 0 in both modes.

Reset
- REQ-025 While reset is low, all pipeline valid bits, out_valid, result and sat_flag SHALL be 0, asynchronously.
- REQ-026 Data registers inside the tree MAY be left unreset; valid bits SHALL be reset.
- REQ-027 Sample sets in flight when reset asserts SHALL be discarded; the first out_valid after release SHALL come LOG2_CH+1 cycles after the first post-release in_valid.

Structure
- REQ-028 A shared package SHALL hold SAMPLE_W's default, a clog2-style function, and the saturate function used by the output stage.
- REQ-029 One sub-module, wave_sum_stage (parameterised pairwise add + register for a single level, with valid), SHALL be instantiated LOG2_CH times in a generate loop.

Verification (NUM_CH=4, SAMPLE_W=16, LOG2_CH=2)
- REQ-030 Samples {1000,2000,-500,3} all enabled, avg_mode=0, one in_valid pulse -> out_valid exactly 3 cycles later, result=2503, sat_flag=0.
- REQ-031 Samples all 32767, avg_mode=0 -> result=32767, sat_flag=1; then all -32768 -> result=-32768; sat_clr pulse with no clip -> sat_flag=0.
- REQ-032 Same all-32767 set with avg_mode=1 -> result=32767, sat_flag=0; samples {-1,0,0,0} with avg_mode=1 -> result=-1 (floor).
- REQ-033 Back-to-back in_valid for 8 cycles while avg_mode and ch_en toggle each cycle -> 8 consecutive out_valid, each result matching its own captured mode and mask.
- REQ-034 Reset asserted for 1 cycle while 2 sets are in flight -> out_valid stays 0 for those sets, all outputs 0, and normal 3-cycle latency resumes after release.
- REQ-035 ch_en=4'b0101 with samples {100,200,300,400} (channel 0 first) -> result=400; ch_en=0 -> result=0.

Source files
------------

// File: rtl/wave_sum_tree_pkg.sv
// Shared definitions for the wave_sum_tree mixer: default widths, mode encoding,
// a constant log2 helper and the output saturation function.
package wave_sum_tree_pkg;

    localparam int DEFAULT_NUM_CH   = 64;
    localparam int DEFAULT_SAMPLE_W = 16;
    // Working width for the saturation step; accumulator widths must stay below this.
    localparam int WIDE_W           = 64;

    typedef enum logic {
        MODE_SUM  = 1'b0,
        MODE_MEAN = 1'b1
    } mix_mode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Clamp a signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [WIDE_W-1:0] saturate(
        input logic signed [WIDE_W-1:0] value,
        input int                       width
    );
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/wave_sum_stage.sv
// One adder-tree level: sums adjacent signed operand pairs into results one bit
// wider and registers them together with the valid bit and the carried mode bit.
module wave_sum_stage
    import wave_sum_tree_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int IN_W = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_avg,
    input  logic [N_IN*IN_W-1:0]             in_data,
    output logic                             out_valid,
    output logic                             out_avg,
    output logic [(N_IN/2)*(IN_W+1)-1:0]     out_data
);

    localparam int N_OUT = N_IN / 2;
    localparam int OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] sum_next;
    logic [N_OUT*OUT_W-1:0] sum_reg;
    logic                   valid_reg;
    logic                   avg_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_pair
            logic [IN_W-1:0] op_a;
            logic [IN_W-1:0] op_b;
            assign op_a = in_data[(2*gi)*IN_W +: IN_W];
            assign op_b = in_data[(2*gi+1)*IN_W +: IN_W];
            // Sign-extend by one bit so the pair sum can never overflow.
            assign sum_next[gi*OUT_W +: OUT_W] = {op_a[IN_W-1], op_a} + {op_b[IN_W-1], op_b};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
        end
    end

    // Data and mode travel unreset; only the valid bit qualifies them.
    always_ff @(posedge clk) begin
        sum_reg <= sum_next;
        avg_reg <= in_avg;
    end

    assign out_valid = valid_reg;
    assign out_avg   = avg_reg;
    assign out_data  = sum_reg;

endmodule

// File: rtl/wave_sum_tree.sv
// Pipelined multi-channel mixer: masked channels go through a registered binary
// adder tree, then a registered output stage applies saturating sum or mean.
module wave_sum_tree
    import wave_sum_tree_pkg::*;
#(
    parameter int NUM_CH   = DEFAULT_NUM_CH,
    parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] samples,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic                       avg_mode,
    input  logic                       sat_clr,
    output logic                       out_valid,
    output logic [SAMPLE_W-1:0]        result,
    output logic                       sat_flag
);

    localparam int LOG2_CH = clog2(NUM_CH);
    localparam int ACC_W   = SAMPLE_W + LOG2_CH;

    logic [NUM_CH*SAMPLE_W-1:0] masked;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_mask
            assign masked[gi*SAMPLE_W +: SAMPLE_W] =
                ch_en[gi] ? samples[gi*SAMPLE_W +: SAMPLE_W] : '0;
        end

        // Level gi holds NUM_CH>>gi operands of SAMPLE_W+gi bits on its input.
        for (gi = 0; gi < LOG2_CH; gi++) begin : g_lvl
            localparam int N_IN = NUM_CH >> gi;
            localparam int IN_W = SAMPLE_W + gi;

            logic [N_IN*IN_W-1:0]             lvl_in;
            logic                             lvl_in_valid;
            logic                             lvl_in_avg;
            logic [(N_IN/2)*(IN_W+1)-1:0]     lvl_out;
            logic                             lvl_out_valid;
            logic                             lvl_out_avg;

            if (gi == 0) begin : g_first
                assign lvl_in       = masked;
                assign lvl_in_valid = in_valid;
                assign lvl_in_avg   = avg_mode;
            end else begin : g_next
                assign lvl_in       = g_lvl[gi-1].lvl_out;
                assign lvl_in_valid = g_lvl[gi-1].lvl_out_valid;
                assign lvl_in_avg   = g_lvl[gi-1].lvl_out_avg;
            end

            wave_sum_stage #(
                .N_IN (N_IN),
                .IN_W (IN_W)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (lvl_in_valid),
                .in_avg    (lvl_in_avg),
                .in_data   (lvl_in),
                .out_valid (lvl_out_valid),
                .out_avg   (lvl_out_avg),
                .out_data  (lvl_out)
            );
        end
    endgenerate

    logic signed [ACC_W-1:0]  final_sum;
    logic                     final_valid;
    mix_mode_e                final_mode;
    logic signed [WIDE_W-1:0] wide_sum;
    logic signed [WIDE_W-1:0] sat_wide;
    logic [SAMPLE_W-1:0]      mean_res;
    logic [SAMPLE_W-1:0]      sat_res;
    logic                     clipped;
    logic                     clip_now;

    assign final_sum   = g_lvl[LOG2_CH-1].lvl_out;
    assign final_valid = g_lvl[LOG2_CH-1].lvl_out_valid;
    assign final_mode  = mix_mode_e'(g_lvl[LOG2_CH-1].lvl_out_avg);

    assign wide_sum = WIDE_W'(final_sum);
    assign sat_wide = saturate(wide_sum, SAMPLE_W);
    assign clipped  = (sat_wide != wide_sum);
    assign sat_res  = SAMPLE_W'(sat_wide);
    // Floor mean of NUM_CH channels always fits back into SAMPLE_W.
    assign mean_res = SAMPLE_W'(final_sum >>> LOG2_CH);
    assign clip_now = final_valid && (final_mode == MODE_SUM) && clipped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= final_valid;
            if (final_valid) begin
                result <= (final_mode == MODE_MEAN) ? mean_res : sat_res;
            end
            // A coincident clip takes priority over the clear request.
            if (clip_now) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wave_sum_tree.sv
// Scoreboard bench for wave_sum_tree at NUM_CH=4, SAMPLE_W=16: the driver queues
// hand-computed expectations, a negedge monitor checks each output as it appears.
module tb_wave_sum_tree;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 16;
    localparam int LATENCY  = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       in_valid;
    logic [NUM_CH*SAMPLE_W-1:0] samples;
    logic [NUM_CH-1:0]          ch_en;
    logic                       avg_mode;
    logic                       sat_clr;
    logic                       out_valid;
    logic [SAMPLE_W-1:0]        result;
    logic                       sat_flag;

    always #5 clk = ~clk;

    wave_sum_tree #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .samples   (samples),
        .ch_en     (ch_en),
        .avg_mode  (avg_mode),
        .sat_clr   (sat_clr),
        .out_valid (out_valid),
        .result    (result),
        .sat_flag  (sat_flag)
    );

    typedef struct {
        int res;
        bit sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   exp_last = 0;
    bit   model_sat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per out_valid, otherwise checks result holds.
    always @(negedge clk) begin
        if (!reset) begin
            exp_last = 0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got result %0d expected no output (cycle %0d)",
                         $signed(result), cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", $signed(result), e.res);
                check("sat_flag", sat_flag, e.sat);
                check("latency", cyc - e.cyc, LATENCY);
                $display("out: result=%0d sat_flag=%0b expected=%0d/%0b latency=%0d",
                         $signed(result), sat_flag, e.res, e.sat, cyc - e.cyc);
                exp_last = e.res;
            end
        end else begin
            check("hold", $signed(result), exp_last);
        end
    end

    task automatic issue(input int s0, input int s1, input int s2, input int s3,
                         input logic [3:0] en, input bit avg, input int exp, input bit clip);
        exp_t e;
        samples  = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
        ch_en    = en;
        avg_mode = avg;
        in_valid = 1'b1;
        model_sat = model_sat | clip;
        e.res = exp;
        e.sat = model_sat;
        e.cyc = cyc;
        q.push_back(e);
        $display("in: samples={%0d,%0d,%0d,%0d} ch_en=%b avg=%0b expect=%0d", s0, s1, s2, s3, en, avg, exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0 pending", q.size());
            q.delete();
        end
    endtask

    logic [3:0] en_seq  [8] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
                                4'b1111, 4'b0011, 4'b1100, 4'b0001};
    bit         avg_seq [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int         exp_seq [8] = '{6001, -250, 7001, 250, 1500, -1000, 1750, 1000};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        samples   = '0;
        ch_en     = '0;
        avg_mode  = 1'b0;
        sat_clr   = 1'b0;
        model_sat = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", $signed(result), 0);
        check("reset_sat_flag", sat_flag, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        issue(1000, 2000, -500, 3, 4'b1111, 1'b0, 2503, 1'b0);
        drain();

        issue(32767, 32767, 32767, 32767, 4'b1111, 1'b0, 32767, 1'b1);
        issue(-32768, -32768, -32768, -32768, 4'b1111, 1'b0, -32768, 1'b1);
        drain();

        sat_clr   = 1'b1;
        model_sat = 1'b0;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        check("sat_clr", sat_flag, 0);

        issue(32767, 32767, 32767, 32767, 4'b1111, 1'b1, 32767, 1'b0);
        issue(-1, 0, 0, 0, 4'b1111, 1'b1, -1, 1'b0);
        drain();

        issue(100, 200, 300, 400, 4'b0101, 1'b0, 400, 1'b0);
        issue(100, 200, 300, 400, 4'b0000, 1'b0, 0, 1'b0);
        issue(100, 200, 300, 400, 4'b0000, 1'b1, 0, 1'b0);
        drain();

        for (int i = 0; i < 8; i++) begin
            issue(1000, -2000, 3000, 4001, en_seq[i], avg_seq[i], exp_seq[i], 1'b0);
        end
        drain();

        // Reset while two clipping sets are in flight: they must vanish.
        issue(32767, 32767, 32767, 32767, 4'b1111, 1'b0, 32767, 1'b1);
        drain();
        issue(32767, 32767, 32767, 32767, 4'b1111, 1'b0, 32767, 1'b1);
        issue(-32768, -32768, -32768, -32768, 4'b1111, 1'b0, -32768, 1'b1);
        reset = 1'b0;
        q.delete();
        model_sat = 1'b0;
        #1;
        check("inflight_reset_out_valid", out_valid, 0);
        check("inflight_reset_result", $signed(result), 0);
        check("inflight_reset_sat_flag", sat_flag, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_sat_flag", sat_flag, 0);

        issue(1000, 2000, -500, 3, 4'b1111, 1'b0, 2503, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
